// File: rtl/ising_pkg.sv
// ising_pkg: definitions shared by the spin readout slice.
//   ISING_N   - default oscillator count, also used by the oscillator array
//   state_t   - readout FSM states (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//   cnt_width - width of a counter that must hold values 0..max_val
package ising_pkg;

    localparam int unsigned ISING_N = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spin_sampler_if.sv
// spin_sampler_if: result handshake of the spin readout.
//   spins       - spin vector, bit 0 is the phase reference and always 0
//   spins_valid - spins holds a result
//   spins_ready - consumer accepts the result
// master: the sampler (drives spins/spins_valid); slave: the consumer.
interface spin_sampler_if
    import ising_pkg::*;
#(
    parameter int unsigned N = ISING_N
);
    logic [N-1:0] spins;
    logic         spins_valid;
    logic         spins_ready;

    modport master (output spins, output spins_valid, input spins_ready);
    modport slave  (input spins, input spins_valid, output spins_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchronizer with synchronous active-low reset.
//   clk  - destination clock
//   rstn - synchronous active-low reset, clears both stages
//   i_d  - asynchronous input bits
//   o_q  - synchronized bits (two clk cycles of latency)
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/spin_sampler.sv
// spin_sampler: readout stage for the coupled ring-oscillator array.
// Releases the oscillators' reset on a start request, waits SETTLE_CYCLES,
// then counts for WINDOW_CYCLES how often each oscillator differs from
// oscillator 0. An oscillator whose mismatch count exceeds half the window
// reads as spin 1.
//   clk, rstn  - clock, synchronous active-low reset
//   start      - readout request, honoured only in IDLE
//   busy       - high whenever the FSM is not IDLE
//   osc_in     - raw asynchronous oscillator outputs, osc_in[0] is reference
//   osc_rstn   - registered oscillator reset, 0 holds them in reset
//   res        - spins / spins_valid / spins_ready result handshake
//   mismatch_counts - per-oscillator final counts, CNT_W bits each, slot 0
//                     reads 0; present only with SPIN_SAMPLER_COUNTS_EN
module spin_sampler
    import ising_pkg::*;
#(
    parameter int unsigned N             = ISING_N,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned WINDOW_CYCLES = 256,
    localparam int unsigned CNT_W        = cnt_width(WINDOW_CYCLES)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    output logic         busy,
    input  logic [N-1:0] osc_in,
    output logic         osc_rstn,
    spin_sampler_if.master res
`ifdef SPIN_SAMPLER_COUNTS_EN
    ,
    output logic [N*CNT_W-1:0] mismatch_counts
`endif
);
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_start;
    logic             r_osc_rstn;
    logic [N-1:0]     w_s;
    logic [N-1:0]     r_spins;
    logic [SET_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_cnt [1:N-1];
    logic [CNT_W-1:0] w_cnt_next [N];
    logic             w_settle_last;
    logic             w_window_last;

    sync_2ff #(.W(N)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (osc_in),
        .o_q  (w_s)
    );

    assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign w_window_last = (r_win_cnt == CNT_W'(WINDOW_CYCLES - 1));

    // start is registered before the FSM sees it, so a request sampled at
    // edge T moves the FSM to SETTLE (and releases osc_rstn) at edge T+1.
    // Only requests seen while IDLE are kept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_start    <= 1'b0;
            r_osc_rstn <= 1'b0;
        end else begin
            r_start    <= start && (r_state == S_IDLE);
            r_osc_rstn <= (w_next_state != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (r_start)                          w_next_state = S_SETTLE;
            S_SETTLE: if (w_settle_last)                    w_next_state = S_SAMPLE;
            S_SAMPLE: if (w_window_last)                    w_next_state = S_DONE;
            S_DONE:   if (res.spins_valid && res.spins_ready) w_next_state = S_IDLE;
            default:                                        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        res.spins_valid = (r_state == S_DONE);
    end

    assign osc_rstn  = r_osc_rstn;
    assign res.spins = r_spins;

    // Count including the current sample; slot 0 stays 0 so the
    // reference never produces a spin or a nonzero count.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_cnt_next[i] = '0;
        end
        for (int unsigned i = 1; i < N; i++) begin
            w_cnt_next[i] = r_cnt[i] + CNT_W'(w_s[i] ^ w_s[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_spins      <= '0;
            for (int unsigned i = 1; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                    if (w_settle_last) begin
                        r_win_cnt <= '0;
                        for (int unsigned i = 1; i < N; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
                S_SAMPLE: begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    for (int unsigned i = 1; i < N; i++) begin
                        r_cnt[i] <= w_cnt_next[i];
                    end
                    if (w_window_last) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            r_spins[i] <= (w_cnt_next[i] > CNT_W'(WINDOW_CYCLES / 2));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPIN_SAMPLER_COUNTS_EN
    logic [N*CNT_W-1:0] r_counts;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_counts <= '0;
        end else if (r_state == S_SAMPLE && w_window_last) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_counts[i*CNT_W +: CNT_W] <= w_cnt_next[i];
            end
        end
    end

    assign mismatch_counts = r_counts;
`endif

endmodule

// File: tb/tb_spin_sampler.sv
`timescale 1ns/1ps
module tb_spin_sampler;
    import ising_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned SC = 8;
    localparam int unsigned WC = 16;
    localparam int unsigned CW = $clog2(WC + 1);
    localparam int unsigned LAT = 1 + SC + WC;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         busy;
    logic         osc_rstn;
    logic [N-1:0] osc_in;

    spin_sampler_if #(.N(N)) res_if ();
`ifdef SPIN_SAMPLER_COUNTS_EN
    logic [N*CW-1:0] mismatch_counts;
`endif

    spin_sampler #(
        .N             (N),
        .SETTLE_CYCLES (SC),
        .WINDOW_CYCLES (WC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .busy     (busy),
        .osc_in   (osc_in),
        .osc_rstn (osc_rstn),
        .res      (res_if)
`ifdef SPIN_SAMPLER_COUNTS_EN
        ,
        .mismatch_counts (mismatch_counts)
`endif
    );

    always #5 clk = ~clk;

    // Oscillator stimulus: osc 0 is a square wave toggling every 2 clk or
    // constant 0; other bits are 0, 1, follow osc 0, invert osc 0, or a
    // single pulse of pulse_len cycles starting at cycle pulse_start.
    int          cyc = 0;
    bit          sq_mode;
    int unsigned bmode [N];
    int          pulse_start;
    int          pulse_len;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        osc_in[0] = sq_mode ? cyc[1] : 1'b0;
        for (int b = 1; b < N; b++) begin
            case (bmode[b])
                0:       osc_in[b] = 1'b0;
                1:       osc_in[b] = 1'b1;
                2:       osc_in[b] = osc_in[0];
                3:       osc_in[b] = ~osc_in[0];
                default: osc_in[b] = (cyc >= pulse_start) && (cyc < pulse_start + pulse_len);
            endcase
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0]    spins;
        logic [N*CW-1:0] counts;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        bit           sq;
        int unsigned  m1, m2, m3;
        int           plen;
        logic [N-1:0] spins;
        int unsigned  c1, c2, c3;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [N*CW-1:0] mk_counts(input int unsigned c1, input int unsigned c2,
                                                  input int unsigned c3);
        logic [N*CW-1:0] r;
        r = '0;
        r[1*CW +: CW] = CW'(c1);
        r[2*CW +: CW] = CW'(c2);
        r[3*CW +: CW] = CW'(c3);
        return r;
    endfunction

    task automatic configure(input vec_t v);
        sq_mode   = v.sq;
        bmode[1]  = v.m1;
        bmode[2]  = v.m2;
        bmode[3]  = v.m3;
        pulse_len = v.plen;
    endtask

    // One full readout. stray: tick index after T at which an extra start is
    // pulsed (0 = none). bp: hold spins_ready low 10 cycles in DONE.
    task automatic run_readout(input string tag, input vec_t v, input int stray, input bit bp);
        exp_t e;
        exp_t got;
        int   n;
        configure(v);
        pulse_start = cyc + 1 + 10;
        e.spins  = v.spins;
        e.counts = mk_counts(v.c1, v.c2, v.c3);
        sbq.push_back(e);
        start = 1'b1;
        tick();                              // edge T
        start = 1'b0;
        chk({tag, "_osc_rstn_T"}, {31'd0, osc_rstn}, 32'd0);
        tick();                              // edge T+1
        chk({tag, "_osc_rstn_T1"}, {31'd0, osc_rstn}, 32'd1);
        chk({tag, "_busy_T1"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!res_if.spins_valid && n < 60) begin
            if (n == stray) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, res_if.spins_valid}, 32'd1);
        chk({tag, "_latency"}, n, LAT);
        got = sbq.pop_front();
        chk({tag, "_spins"}, {28'd0, res_if.spins}, {28'd0, got.spins});
`ifdef SPIN_SAMPLER_COUNTS_EN
        chk({tag, "_counts"}, {12'd0, mismatch_counts}, {12'd0, got.counts});
`endif
        if (bp) begin
            for (int k = 0; k < 10; k++) begin
                start = (k == 2 || k == 5);
                tick();
                start = 1'b0;
                chk({tag, "_bp_valid"}, {31'd0, res_if.spins_valid}, 32'd1);
                chk({tag, "_bp_spins"}, {28'd0, res_if.spins}, {28'd0, got.spins});
                chk({tag, "_bp_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_bp_osc_rstn"}, {31'd0, osc_rstn}, 32'd1);
            end
        end
        res_if.spins_ready = 1'b1;
        tick();
        res_if.spins_ready = 1'b0;
        chk({tag, "_acc_valid"}, {31'd0, res_if.spins_valid}, 32'd0);
        chk({tag, "_acc_osc_rstn"}, {31'd0, osc_rstn}, 32'd0);
        chk({tag, "_acc_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_acc_spins_hold"}, {28'd0, res_if.spins}, {28'd0, got.spins});
        tick();
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            sq  m1 m2 m3 plen spins    c1  c2  c3
        vecs[0] = '{1'b1, 2, 3, 0, 0, 4'b0100,  0, 16,  8};
        vecs[1] = '{1'b0, 0, 1, 4, 9, 4'b1100,  0, 16,  9};
        vecs[2] = '{1'b0, 0, 1, 4, 8, 4'b0100,  0, 16,  8};
        vecs[3] = '{1'b0, 1, 0, 4, 7, 4'b0010, 16,  0,  7};
        vecs[4] = '{1'b1, 3, 2, 1, 0, 4'b0010, 16,  0,  8};

        configure(vecs[0]);
        pulse_start        = 0;
        rstn               = 1'b0;
        start              = 1'b1;
        res_if.spins_ready = 1'b0;

        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_osc_rstn", {31'd0, osc_rstn}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_valid", {31'd0, res_if.spins_valid}, 32'd0);
            chk("rst_spins", {28'd0, res_if.spins}, 32'd0);
        end
        start = 1'b0;
        rstn  = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_readout($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
        end

        run_readout("stray_start", vecs[1], 12, 1'b0);
        run_readout("backpressure", vecs[0], 0, 1'b1);

        // Reset in the middle of SAMPLE, after a nonzero result is held.
        configure(vecs[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_osc_rstn", {31'd0, osc_rstn}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_valid", {31'd0, res_if.spins_valid}, 32'd0);
        chk("mid_spins", {28'd0, res_if.spins}, 32'd0);
`ifdef SPIN_SAMPLER_COUNTS_EN
        chk("mid_counts", {12'd0, mismatch_counts}, 32'd0);
`endif
        tick();
        run_readout("after_mid_rst", vecs[1], 0, 1'b0);

        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
